// File: rtl/npu_drain_pkg.sv
// npu_drain_pkg: shared types and constants for the NPU output drain.
package npu_drain_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DEQ   = 2'd1,
        FLUSH = 2'd2,
        HOLD  = 2'd3
    } drain_state_t;

    // Settle cycles after a burst so the upstream count and request catch up.
    localparam int unsigned HOLD_CYCLES   = 2;
    localparam int unsigned DEFAULT_BURST = 8;
    localparam int unsigned DEFAULT_DEPTH = 16;

endpackage

// File: rtl/npu_drain_fifo.sv
// npu_drain_fifo: synchronous first-word-fall-through result buffer.
// Writes on full and pops on empty are ignored; level and flags are registered.
module npu_drain_fifo
    import npu_drain_pkg::*;
#(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned DEPTH  = DEFAULT_DEPTH
) (
    input  logic                     clk,
    input  logic                     hreset,
    input  logic                     flush,
    input  logic                     wr_en,
    input  logic [DATA_W-1:0]        wr_data,
    input  logic                     rd_pop,
    output logic [DATA_W-1:0]        rd_data,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     empty,
    output logic                     full
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [AW-1:0]     wr_ptr_q;
    logic [AW-1:0]     rd_ptr_q;
    logic [AW:0]       level_q;
    logic [AW:0]       level_d;
    logic              empty_q;
    logic              full_q;
    logic              wr_ok;
    logic              pop_ok;

    // Qualify requests against current flags and derive the next occupancy.
    always_comb begin
        wr_ok   = wr_en && !full_q;
        pop_ok  = rd_pop && !empty_q;
        level_d = level_q;
        case ({wr_ok, pop_ok})
            2'b10:   level_d = level_q + 1'b1;
            2'b01:   level_d = level_q - 1'b1;
            default: level_d = level_q;
        endcase
    end

    // Pointer, level and flag registers; reset and flush empty the buffer.
    always_ff @(posedge clk) begin
        if (!hreset || flush) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            empty_q  <= 1'b1;
            full_q   <= 1'b0;
        end else begin
            if (wr_ok) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (pop_ok) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            level_q <= level_d;
            empty_q <= (level_d == '0);
            full_q  <= (level_d == (AW+1)'(DEPTH));
        end
    end

    // Storage array; contents need no reset since the pointers gate visibility.
    always_ff @(posedge clk) begin
        if (wr_ok) begin
            mem_q[wr_ptr_q] <= wr_data;
        end
    end

    // Head is forced to zero while empty so stale entries never leak out.
    assign rd_data = empty_q ? '0 : mem_q[rd_ptr_q];
    assign level   = level_q;
    assign empty   = empty_q;
    assign full    = full_q;

endmodule

// File: rtl/npu_out_drain.sv
// npu_out_drain: turns burst requests into bounded NPU output FIFO dequeues
// and lands the returned words in a local FWFT buffer for the AHB read side.
// Optional macro NPU_OUT_DRAIN_ERR_EN enables the sticky err_int checks.
module npu_out_drain
    import npu_drain_pkg::*;
#(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned DEPTH  = DEFAULT_DEPTH,
    parameter int unsigned BURST  = DEFAULT_BURST
) (
    input  logic                     clk,
    input  logic                     hreset,
    input  logic                     stop,
    input  logic                     wrt_req_en,
    input  logic [9:0]               output_count,
    input  logic [31:0]              residue_out_cnt,
    output logic                     npu_deq,
    input  logic [DATA_W-1:0]        npu_dout,
    input  logic                     rd_pop,
    output logic [DATA_W-1:0]        rd_data,
    output logic                     out_empty,
    output logic                     out_full,
    output logic [$clog2(DEPTH):0]   out_level,
    output logic                     burst_done,
    output logic                     err_int
);

    localparam int unsigned CW = $clog2(BURST) + 1;
    localparam int unsigned HW = $clog2(HOLD_CYCLES) + 1;

    drain_state_t  state_q;
    drain_state_t  state_d;
    logic [CW-1:0] rem_q;
    logic [CW-1:0] rem_d;
    logic [HW-1:0] hold_q;
    logic [HW-1:0] hold_d;
    logic          cap_q;
    logic          burst_done_q;
    logic [31:0]   len_w;
    logic          start;

    // Burst sizing, admission check and state transitions.
    always_comb begin
        state_d = state_q;
        rem_d   = rem_q;
        hold_d  = hold_q;

        // A zero residue means the run length is unknown, so it does not limit.
        len_w = 32'(BURST);
        if (32'(output_count) < len_w) begin
            len_w = 32'(output_count);
        end
        if ((residue_out_cnt != '0) && (residue_out_cnt < len_w)) begin
            len_w = residue_out_cnt;
        end

        start = wrt_req_en && (output_count != '0) &&
                ((32'(DEPTH) - 32'(out_level)) >= 32'(BURST));

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = DEQ;
                    rem_d   = CW'(len_w);
                end
            end
            DEQ: begin
                rem_d = rem_q - 1'b1;
                if (rem_q == CW'(1)) begin
                    state_d = FLUSH;
                end
            end
            FLUSH: begin
                state_d = HOLD;
                hold_d  = '0;
            end
            HOLD: begin
                if (hold_q == HW'(HOLD_CYCLES - 1)) begin
                    state_d = IDLE;
                end else begin
                    hold_d = hold_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // FSM, burst counter, capture strobe and done pulse; stop acts as reset.
    always_ff @(posedge clk) begin
        if (!hreset || stop) begin
            state_q      <= IDLE;
            rem_q        <= '0;
            hold_q       <= '0;
            cap_q        <= 1'b0;
            burst_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            rem_q        <= rem_d;
            hold_q       <= hold_d;
            cap_q        <= npu_deq;
            burst_done_q <= (state_q == FLUSH);
        end
    end

    assign npu_deq    = (state_q == DEQ);
    assign burst_done = burst_done_q;

    npu_drain_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .hreset  (hreset),
        .flush   (stop),
        .wr_en   (cap_q),
        .wr_data (npu_dout),
        .rd_pop  (rd_pop),
        .rd_data (rd_data),
        .level   (out_level),
        .empty   (out_empty),
        .full    (out_full)
    );

`ifdef NPU_OUT_DRAIN_ERR_EN
    logic err_q;

    // Sticky error on pop-while-empty or capture-while-full.
    always_ff @(posedge clk) begin
        if (!hreset || stop) begin
            err_q <= 1'b0;
        end else if ((rd_pop && out_empty) || (cap_q && out_full)) begin
            err_q <= 1'b1;
        end
    end

    assign err_int = err_q;
`else
    assign err_int = 1'b0;
`endif

endmodule

// File: tb/tb_npu_out_drain.sv
// tb_npu_out_drain: directed scoreboard bench for npu_out_drain.
module tb_npu_out_drain;

    logic        clk = 1'b0;
    logic        hreset;
    logic        stop;
    logic        wrt_req_en;
    logic [9:0]  output_count;
    logic [31:0] residue_out_cnt;
    logic        npu_deq;
    logic [31:0] npu_dout = '0;
    logic        rd_pop;
    logic [31:0] rd_data;
    logic        out_empty;
    logic        out_full;
    logic [4:0]  out_level;
    logic        burst_done;
    logic        err_int;

    int checks = 0;
    int errors = 0;
    int deq_cnt = 0;
    int bd_cnt = 0;
    int d0;
    int b0;
    logic [31:0] seq_ctr = 32'hC0DE_0000;
    logic [31:0] exp_q[$];
    logic        exp_err;

    npu_out_drain #(
        .DATA_W (32),
        .DEPTH  (16),
        .BURST  (8)
    ) dut (
        .clk             (clk),
        .hreset          (hreset),
        .stop            (stop),
        .wrt_req_en      (wrt_req_en),
        .output_count    (output_count),
        .residue_out_cnt (residue_out_cnt),
        .npu_deq         (npu_deq),
        .npu_dout        (npu_dout),
        .rd_pop          (rd_pop),
        .rd_data         (rd_data),
        .out_empty       (out_empty),
        .out_full        (out_full),
        .out_level       (out_level),
        .burst_done      (burst_done),
        .err_int         (err_int)
    );

    always #5 clk = ~clk;

    // NPU output FIFO model: data follows the strobe by one cycle; scoreboard push.
    always @(posedge clk) begin
        if (npu_deq === 1'b1) begin
            npu_dout <= seq_ctr;
            exp_q.push_back(seq_ctr);
            seq_ctr  <= seq_ctr + 1;
            deq_cnt  <= deq_cnt + 1;
        end
        if (burst_done === 1'b1) begin
            bd_cnt <= bd_cnt + 1;
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run(input int n);
        repeat (n) tick();
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic pop_chk(input string tag);
        logic [31:0] e;
        if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $error("FAIL %s observed=%0h expected=none_queued", tag, rd_data);
        end else begin
            e = exp_q.pop_front();
            chk(tag, rd_data, e);
        end
        rd_pop = 1'b1;
        tick();
        rd_pop = 1'b0;
    endtask

    task automatic pulse_req();
        wrt_req_en = 1'b1;
        tick();
        wrt_req_en = 1'b0;
    endtask

    initial begin
`ifdef NPU_OUT_DRAIN_ERR_EN
        exp_err = 1'b1;
`else
        exp_err = 1'b0;
`endif
        hreset = 1'b0;
        stop = 1'b0;
        wrt_req_en = 1'b0;
        rd_pop = 1'b0;
        output_count = '0;
        residue_out_cnt = '0;
        run(3);

        // Reset values
        chk("rst_deq", 32'(npu_deq), 32'd0);
        chk("rst_empty", 32'(out_empty), 32'd1);
        chk("rst_full", 32'(out_full), 32'd0);
        chk("rst_level", 32'(out_level), 32'd0);
        chk("rst_done", 32'(burst_done), 32'd0);
        chk("rst_err", 32'(err_int), 32'd0);
        chk("rst_rdata", rd_data, 32'd0);
        hreset = 1'b1;
        run(2);

        // Single full burst with latency checks
        output_count = 10'd12;
        residue_out_cnt = 32'd100;
        d0 = deq_cnt;
        b0 = bd_cnt;
        pulse_req();
        chk("req_to_deq", 32'(npu_deq), 32'd1);
        tick();
        chk("empty_before_land", 32'(out_empty), 32'd1);
        tick();
        chk("land_level", 32'(out_level), 32'd1);
        chk("land_data", rd_data, exp_q[0]);
        run(10);
        chk("b1_deq_count", 32'(deq_cnt - d0), 32'd8);
        chk("b1_level", 32'(out_level), 32'd8);
        chk("b1_done_once", 32'(bd_cnt - b0), 32'd1);
        chk("b1_not_full", 32'(out_full), 32'd0);
        for (int i = 0; i < 8; i++) pop_chk("b1_data");
        chk("b1_drained", 32'(out_empty), 32'd1);

        // Residue-limited tail
        output_count = 10'd3;
        residue_out_cnt = 32'd3;
        d0 = deq_cnt;
        pulse_req();
        run(8);
        chk("res_deq_count", 32'(deq_cnt - d0), 32'd3);
        chk("res_level", 32'(out_level), 32'd3);
        for (int i = 0; i < 3; i++) pop_chk("res_data");

        // Backpressure: fill to 9, then a held request must wait for space
        output_count = 10'd12;
        residue_out_cnt = 32'd0;
        pulse_req();
        run(12);
        output_count = 10'd1;
        pulse_req();
        run(6);
        chk("bp_level9", 32'(out_level), 32'd9);
        output_count = 10'd12;
        d0 = deq_cnt;
        wrt_req_en = 1'b1;
        run(6);
        chk("bp_no_deq", 32'(deq_cnt - d0), 32'd0);
        pop_chk("bp_pop1");
        run(14);
        wrt_req_en = 1'b0;
        chk("bp_deq_count", 32'(deq_cnt - d0), 32'd8);
        chk("bp_level16", 32'(out_level), 32'd16);
        chk("bp_full", 32'(out_full), 32'd1);
        for (int i = 0; i < 16; i++) pop_chk("bp_data");
        chk("bp_drained", 32'(out_empty), 32'd1);

        // Concurrent pop and write across the pointer wrap
        output_count = 10'd4;
        pulse_req();
        run(7);
        chk("cc_level4", 32'(out_level), 32'd4);
        output_count = 10'd12;
        wrt_req_en = 1'b1;
        pop_chk("cc_data");
        wrt_req_en = 1'b0;
        for (int i = 0; i < 7; i++) pop_chk("cc_data");
        run(4);
        chk("cc_final_level", 32'(out_level), 32'd4);
        for (int i = 0; i < 4; i++) pop_chk("cc_tail");

        // Stop in the third DEQ cycle
        output_count = 10'd12;
        d0 = deq_cnt;
        pulse_req();
        tick();
        tick();
        chk("stop_third_deq", 32'(npu_deq), 32'd1);
        stop = 1'b1;
        tick();
        stop = 1'b0;
        exp_q.delete();
        chk("stop_deq_low", 32'(npu_deq), 32'd0);
        chk("stop_level", 32'(out_level), 32'd0);
        chk("stop_empty", 32'(out_empty), 32'd1);
        run(3);
        chk("stop_deq_count", 32'(deq_cnt - d0), 32'd3);
        chk("stop_level_held", 32'(out_level), 32'd0);
        output_count = 10'd2;
        pulse_req();
        chk("stop_idle_restart", 32'(npu_deq), 32'd1);
        run(6);
        for (int i = 0; i < 2; i++) pop_chk("stop_after_data");

        // Pop on empty
        rd_pop = 1'b1;
        tick();
        rd_pop = 1'b0;
        chk("pe_level", 32'(out_level), 32'd0);
        chk("pe_empty", 32'(out_empty), 32'd1);
        chk("pe_err", 32'(err_int), 32'(exp_err));
        run(3);
        chk("pe_err_sticky", 32'(err_int), 32'(exp_err));
        stop = 1'b1;
        tick();
        stop = 1'b0;
        chk("pe_err_cleared", 32'(err_int), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/npu_out_drain.md
# npu_out_drain

Downstream companion of the NPU interface controller. It turns the controller's registered `wrt_req_en` into bounded dequeue bursts from the NPU output FIFO and captures the returned results into a 16-entry first-word-fall-through buffer. The AHB slave read path pops that buffer. One burst is in flight at a time, and the block never dequeues more words than the buffer can accept.

## Interface
Parameters:
- `DATA_W`, default 32: result word width.
- `DEPTH`, default 16: buffer entries; must be a power of two and at least `BURST`.
- `BURST`, default 8: maximum words per dequeue burst.

Ports:
- `clk`  in  1: single clock.
- `hreset`  in  1: reset; synchronous, active-low.
- `stop`  in  1: synchronous abort and flush, same priority as reset.
- `wrt_req_en`  in  1: burst request, registered in the controller.
- `output_count`  in  10: occupancy of the NPU output FIFO.
- `residue_out_cnt`  in  32: words still owed by the current NPU run.
- `npu_deq`  out  1: NPU output FIFO dequeue strobe.
- `npu_dout`  in  DATA_W: NPU result; valid exactly 1 cycle after `npu_deq`.
- `rd_pop`  in  1: AHB-side buffer pop.
- `rd_data`  out  DATA_W: buffer head, combinational.
- `out_empty`  out  1: buffer empty.
- `out_full`  out  1: buffer full.
- `out_level`  out  $clog2(DEPTH)+1: buffer occupancy.
- `burst_done`  out  1: one-cycle pulse after the last word of a burst is written.
- `err_int`  out  1: sticky error flag (see Configuration).

## Operation
- State machine IDLE → DEQ → FLUSH → HOLD → IDLE.
- IDLE:
  - Start a burst when `wrt_req_en`=1 and `output_count`≠0 and (`DEPTH` − `out_level`) ≥ `BURST`.
  - Latch `len` = min(`BURST`, `output_count`, `residue_out_cnt`), where the `residue_out_cnt` term applies only when it is nonzero. Set `rem` = `len`. Go to DEQ.
- DEQ:
  - `npu_deq`=1 every cycle; `rem` decrements.
  - Go to FLUSH when `rem` reaches 1, i.e. after the last strobe cycle.
- Capture path: a registered copy of `npu_deq` writes `npu_dout` into the buffer in the following cycle. Every dequeued word lands exactly once.
- FLUSH: one cycle, which captures the final word; `burst_done`=1 at the end of this cycle.
- HOLD: two idle cycles so that `output_count` and the registered `wrt_req_en` reflect the completed burst; then go to IDLE.
- Buffer:
  - Write and `rd_pop` in the same cycle are both honoured; level stays unchanged.
  - Pop on empty is ignored and does not change state.
  - Pointers wrap modulo `DEPTH`.
- `stop` or reset:
  - State goes to IDLE; pointers, level, `rem` and the capture register clear.
  - Any words in flight are discarded.

## Timing
- Reset values: `npu_deq`=0, `out_empty`=1, `out_full`=0, `out_level`=0, `burst_done`=0, `err_int`=0, `rd_data`=0.
- Request-to-first-`npu_deq`: 1 cycle (IDLE samples the request; DEQ begins in the next cycle).
- `npu_deq` to the word being visible on `rd_data` (buffer previously empty): 2 cycles.
- Burst of N words occupies N+1+2 cycles after IDLE. Minimum request spacing is N+4 cycles.
- `out_level` and the flags are registered and update in the cycle after a write or pop.
- `stop` asserted during DEQ: `npu_deq` deasserts in the next cycle.

## Configuration
- `NPU_OUT_DRAIN_ERR_EN` defined:
  - `err_int` sets on `rd_pop` while empty.
  - `err_int` sets on a capture write while full; that write is dropped.
  - `err_int` clears only on reset or `stop`.
- Undefined: `err_int` is tied to 0 and the check logic is absent. Behaviour is otherwise identical.

## Structure
- Package `npu_drain_pkg`:
  - state enum `drain_state_t` (IDLE, DEQ, FLUSH, HOLD);
  - `HOLD_CYCLES`=2;
  - default `BURST`/`DEPTH` constants.
- Sub-module `npu_drain_fifo`: synchronous first-word-fall-through buffer with write, pop, level, full and empty.
- The top level holds the FSM, the burst counter and the capture register.

## Test plan
- Single burst: `output_count`=12, `residue_out_cnt`=100, `wrt_req_en` pulse → exactly 8 `npu_deq` cycles; `out_level`=8; `burst_done` once; data order preserved.
- Residue tail: `residue_out_cnt`=3, `output_count`=3 → exactly 3 `npu_deq`; `out_level`=3; no fourth strobe.
- Backpressure: buffer at level 9, request held high → no `npu_deq`. After the AHB side pops 1 word → burst of 8 starts, then `out_level`=16 and `out_full`=1.
- Concurrent read/write: `rd_pop` every cycle during a burst of 8 from level 4 → final level 4; sequence intact across the pointer wrap.
- `stop` in the third DEQ cycle → `npu_deq` is low in the next cycle; `out_level`=0; FSM in IDLE.
- With `NPU_OUT_DRAIN_ERR_EN`: `rd_pop` on empty → `err_int`=1 until `stop`. Without the macro → `err_int` stays 0.
